// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, wait-state tolerant imem handshake, one-entry
// skid buffer for load stalls, and the IF/ID register with ID-resolved redirects.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [2:0]  PC_NEXT  = 3'd0,
  parameter logic [2:0]  PC_JUMP  = 3'd1,
  parameter logic [2:0]  PC_JR    = 3'd2,
  parameter logic [2:0]  PC_BEQ   = 3'd3,
  parameter logic [2:0]  PC_BNE   = 3'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_en,
  input  logic        if_rst,
  input  logic [2:0]  pc_src,
  input  logic        rs_rt_equal,
  input  logic [31:0] rs_data,
  if_fetch_stage_if.master imem,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  logic               taken_sel, redirect, accept, req;
  logic [31:0]        p4, target;
  logic signed [31:0] br_off;

  always_comb begin
    taken_sel = 1'b0;
    case (pc_src)
      PC_NEXT: taken_sel = 1'b0;
      PC_JUMP: taken_sel = 1'b1;
      PC_JR:   taken_sel = 1'b1;
      PC_BEQ:  taken_sel = rs_rt_equal;
      PC_BNE:  taken_sel = !rs_rt_equal;
      default: taken_sel = 1'b0;
    endcase
  end

  assign redirect = valid_q && if_en && taken_sel;
  assign p4       = pc_out_q + 32'd4;
  assign br_off   = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

  always_comb begin
    target = p4 + $unsigned(br_off);
    if (pc_src == PC_JUMP)    target = {p4[31:28], inst_q[25:0], 2'b00};
    else if (pc_src == PC_JR) target = rs_data;
  end

  // While draining an abandoned request the bus must keep showing its address,
  // even though pc already points at the redirect target.
  assign req            = ((state_q == FETCH) && !buf_valid_q) || (state_q == DROP);
  assign imem.imem_req  = req;
  assign imem.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
  assign accept         = (state_q == FETCH) && req && imem.imem_ready && !redirect && !if_rst;

  always_comb begin
    state_d     = state_q;
    drop_addr_d = drop_addr_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if ((redirect || if_rst) && req && !imem.imem_ready) begin
               state_d     = DROP;
               drop_addr_d = pc_q;
             end
      DROP:  if (imem.imem_ready) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    if (if_rst) begin
      pc_d        = PC_RESET;
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end else if (redirect) begin
      pc_d        = target;
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (!if_en) begin
        if (accept) begin
          buf_valid_d = 1'b1;
          buf_inst_d  = imem.imem_rdata;
          buf_pc_d    = pc_q;
        end
      end else if (buf_valid_q) begin
        inst_d      = buf_inst_q;
        pc_out_d    = buf_pc_q;
        valid_d     = 1'b1;
        buf_valid_d = 1'b0;
      end else if (accept) begin
        inst_d   = imem.imem_rdata;
        pc_out_d = pc_q;
        valid_d  = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= PC_RESET;
      inst_q      <= 32'd0;
      pc_out_q    <= 32'd0;
      valid_q     <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Payload-only registers; their contents are qualified by buf_valid_q / DROP.
  always_ff @(posedge clk) begin
    buf_inst_q  <= buf_inst_d;
    buf_pc_q    <= buf_pc_d;
    drop_addr_q <= drop_addr_d;
  end

  assign inst_out  = inst_q;
  assign pc_out    = pc_out_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a combinational zero/variable-wait imem model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_en = 1'b1;
  logic        if_rst = 1'b0;
  logic [2:0]  pc_src = 3'd0;
  logic        rs_rt_equal = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic        mem_ready = 1'b1;
  logic [31:0] inst_out, pc_out;
  logic        valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_en       (if_en),
    .if_rst      (if_rst),
    .pc_src      (pc_src),
    .rs_rt_equal (rs_rt_equal),
    .rs_data     (rs_data),
    .imem        (imem_bus),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .valid_out   (valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40)      return 32'h1022_0003;   // beq, imm 3
    else if (a == 32'h54) return 32'h0800_0020;   // j 0x80
    else                  return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
  assign imem_bus.imem_ready = mem_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input logic [31:0] t);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (valid_out && pc_out == t) found = 1'b1;
      else step();
    end
    chk("reach_pc", {31'd0, found}, 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst_addr",  imem_bus.imem_addr, 32'h0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_inst",  inst_out, 32'h0);
    chk("rst_pc",    pc_out, 32'h0);
    step(); step();
    rst_n = 1'b1;

    // Streaming with zero-wait memory
    step();
    chk("e1_req",   {31'd0, imem_bus.imem_req}, 32'd1);
    chk("e1_addr",  imem_bus.imem_addr, 32'h0);
    chk("e1_valid", {31'd0, valid_out}, 32'd0);
    step();
    chk("e2_valid", {31'd0, valid_out}, 32'd1);
    chk("e2_pc",    pc_out, 32'h0);
    chk("e2_inst",  inst_out, 32'hC0DE_0000);
    chk("e2_addr",  imem_bus.imem_addr, 32'h4);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq_pc",   pc_out, 32'(4 * i));
      chk("seq_addr", imem_bus.imem_addr, 32'(4 * i + 4));
    end

    // Wait states at 0x10
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ws_addr",  imem_bus.imem_addr, 32'h10);
      chk("ws_valid", {31'd0, valid_out}, 32'd0);
    end
    mem_ready = 1'b1;
    step();
    chk("ws_pc",   pc_out, 32'h10);
    chk("ws_inst", inst_out, 32'hC0DE_0010);

    // Load stall with accept at 0x20 into skid buffer
    run_until(32'h1C);
    chk("st_addr0", imem_bus.imem_addr, 32'h20);
    if_en = 1'b0;
    step();
    chk("st_req1",   {31'd0, imem_bus.imem_req}, 32'd0);
    chk("st_pc1",    pc_out, 32'h1C);
    chk("st_valid1", {31'd0, valid_out}, 32'd1);
    step();
    chk("st_req2", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("st_pc2",  pc_out, 32'h1C);
    if_en = 1'b1;
    step();
    chk("st_pc3",   pc_out, 32'h20);
    chk("st_inst3", inst_out, 32'hC0DE_0020);
    chk("st_addr3", imem_bus.imem_addr, 32'h24);
    step();
    chk("st_pc4", pc_out, 32'h24);

    // BEQ not taken at 0x40
    run_until(32'h40);
    pc_src = 3'd3; rs_rt_equal = 1'b0;
    step();
    pc_src = 3'd0;
    chk("bnt_pc",    pc_out, 32'h44);
    chk("bnt_valid", {31'd0, valid_out}, 32'd1);
    chk("bnt_addr",  imem_bus.imem_addr, 32'h48);

    // JR while 0x64 is pending with memory stalled
    run_until(32'h60);
    chk("jr_addr0", imem_bus.imem_addr, 32'h64);
    mem_ready = 1'b0; pc_src = 3'd2; rs_data = 32'h100;
    step();
    pc_src = 3'd0;
    chk("jr_valid1", {31'd0, valid_out}, 32'd0);
    chk("jr_req1",   {31'd0, imem_bus.imem_req}, 32'd1);
    chk("jr_addr1",  imem_bus.imem_addr, 32'h64);
    step();
    chk("jr_addr2",  imem_bus.imem_addr, 32'h64);
    mem_ready = 1'b1;
    step();
    chk("jr_valid3", {31'd0, valid_out}, 32'd0);
    chk("jr_addr3",  imem_bus.imem_addr, 32'h100);
    step();
    chk("jr_valid4", {31'd0, valid_out}, 32'd1);
    chk("jr_pc4",    pc_out, 32'h100);

    // JR back to 0x40, then BEQ taken
    pc_src = 3'd2; rs_data = 32'h40;
    step();
    pc_src = 3'd0;
    chk("jr2_addr", imem_bus.imem_addr, 32'h40);
    step();
    chk("jr2_pc", pc_out, 32'h40);
    pc_src = 3'd3; rs_rt_equal = 1'b1;
    step();
    pc_src = 3'd0;
    chk("bt_addr",  imem_bus.imem_addr, 32'h50);
    chk("bt_valid", {31'd0, valid_out}, 32'd0);
    step();
    chk("bt_pc",   pc_out, 32'h50);
    chk("bt_inst", inst_out, 32'hC0DE_0050);

    // Jump from 0x54 to 0x80
    step();
    chk("j_pc0", pc_out, 32'h54);
    pc_src = 3'd1;
    step();
    pc_src = 3'd0;
    chk("j_addr", imem_bus.imem_addr, 32'h80);
    step();
    chk("j_pc", pc_out, 32'h80);

    // Synchronous flush
    if_rst = 1'b1;
    step();
    if_rst = 1'b0;
    chk("fl_valid", {31'd0, valid_out}, 32'd0);
    chk("fl_addr",  imem_bus.imem_addr, 32'h0);
    step();
    chk("fl_pc",    pc_out, 32'h0);
    chk("fl_valid2", {31'd0, valid_out}, 32'd1);

    // Async reset during a stall with the buffer full
    if_en = 1'b0;
    step();
    chk("ar_req0",  {31'd0, imem_bus.imem_req}, 32'd0);
    chk("ar_inst0", inst_out, 32'hC0DE_0000);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, valid_out}, 32'd0);
    chk("ar_inst",  inst_out, 32'h0);
    chk("ar_addr",  imem_bus.imem_addr, 32'h0);
    chk("ar_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    if_en = 1'b1;
    step();
    rst_n = 1'b1;
    chk("ar_req_rel", {31'd0, imem_bus.imem_req}, 32'd0);
    step();
    chk("ar_req_go", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("ar_addr_go", imem_bus.imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
